apb_slave_regs: RTL and testbench

- APB completer (slave) holding a small word-addressed register file.
- It is the target-side counterpart of the team's APB requester FSM. It answers setup/access phases, inserts a programmable number of wait states and completes transfers with pready.
- Reads and writes hit NUM_REGS × DATA_W storage registers. An optional error response flags out-of-range addresses.

---
 rtl/apb_slave_regs.sv | 156 +++++++++++++++
 tb/tb_apb_slave_regs.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regs.sv
// ---------------------------------------------------------------------------
// apb_slave_regs
//
// APB completer in front of a small word-addressed register file.
// A setup phase is captured in IDLE and the transfer moves to ACCESS, where
// pready is held low for WAIT_CYCLES cycles before the transfer completes.
// Writes land in the register file on the completion edge. Reads return the
// addressed register while pready is high. Addresses whose word index is
// NUM_REGS or above are out of range: writes are dropped and reads return 0.
//
// Optional feature macro: APB_SLAVE_PSLVERR_EN
//   defined   - pslverr is raised on completion of an out-of-range access
//   undefined - pslverr is tied low
// ---------------------------------------------------------------------------
module apb_slave_regs #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  // Word index taken from the byte address, and the slice that selects a register.
  localparam int IDX_W     = ADDR_W - 2;
  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   write_q, write_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];

  logic                   cnt_done;
  logic                   in_range;
  logic                   complete;
  logic                   reg_we;
  logic [REG_IDX_W-1:0]   reg_sel;
  logic [31:0]            idx_wide;

  // Byte-lane bits of the address carry no meaning for word registers.
  logic                   unused_addr_lsbs;
  assign unused_addr_lsbs = ^paddr[1:0];

  // Decode of the latched transfer: wait-state count reached, range, completion.
  assign cnt_done = (state_q == ACCESS) && (cnt_q == WAIT_CNT);
  assign idx_wide = 32'(idx_q);
  assign in_range = (idx_wide < 32'(NUM_REGS));
  assign reg_sel  = idx_q[REG_IDX_W-1:0];
  assign complete = cnt_done && psel && penable;
  assign reg_we   = complete && write_q && in_range;

  // State register and latched transfer attributes.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of the others regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic: setup capture, wait-state counting, completion and abort.
  // NOTE: every variable gets a hold default first, so no path through the
  // case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        // Only a genuine setup phase starts a transfer; a stray access
        // strobe without a preceding setup is ignored.
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = '0;
          idx_d   = paddr[ADDR_W-1:2];
          write_d = pwrite;
          wdata_d = pwdata;
        end
      end
      ACCESS: begin
        if (!psel) begin
          // Requester abandoned the transfer: nothing is written.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          if (penable) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: pready, read data and error response from state and counter.
  always_comb begin
    pready  = cnt_done;
    prdata  = '0;
    pslverr = 1'b0;
    if (cnt_done && !write_q && in_range) begin
      prdata = regs_q[reg_sel];
    end
`ifdef APB_SLAVE_PSLVERR_EN
    pslverr = cnt_done && !in_range;
`endif
  end

  // Register file: written only on the completion edge of an in-range write.
  // NOTE: the storage is reset along with the control state because software
  // expects every register to read zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[reg_sel] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_regs
//
// Three instances of apb_slave_regs with WAIT_CYCLES = 1, 0 and 3 share one
// clock. The requester tasks push the expected completion of every transfer
// (read data, error flag, number of low-pready access cycles) into a per-DUT
// queue; a monitor on the falling edge pops and compares at each pready.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_slave_regs;

  localparam int ND = 3;
  localparam int WC0 = 1;
  localparam int WC1 = 0;
  localparam int WC2 = 3;

`ifdef APB_SLAVE_PSLVERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  logic        clk;
  logic        rst     [ND];
  logic        psel    [ND];
  logic        penable [ND];
  logic        pwrite  [ND];
  logic [7:0]  paddr   [ND];
  logic [31:0] pwdata  [ND];
  logic        pready  [ND];
  logic [31:0] prdata  [ND];
  logic        pslverr [ND];

  int   wc [ND] = '{WC0, WC1, WC2};
  int   waits [ND];
  int   xfers [ND];
  exp_t sb0 [$];
  exp_t sb1 [$];
  exp_t sb2 [$];

  int n_checks = 0;
  int n_fail   = 0;

  apb_slave_regs #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(WC0)) u_dut_w1 (
    .clk(clk), .rst(rst[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]), .prdata(prdata[0]),
    .pslverr(pslverr[0])
  );

  apb_slave_regs #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(WC1)) u_dut_w0 (
    .clk(clk), .rst(rst[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]), .prdata(prdata[1]),
    .pslverr(pslverr[1])
  );

  apb_slave_regs #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(WC2)) u_dut_w3 (
    .clk(clk), .rst(rst[2]), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
    .paddr(paddr[2]), .pwdata(pwdata[2]), .pready(pready[2]), .prdata(prdata[2]),
    .pslverr(pslverr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every comparison and reports mismatches.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.waits = wc[d];
    case (d)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  function automatic bit pop(input int d, output exp_t e);
    bit ok;
    ok = 1'b0;
    e.rdata = '0;
    e.err   = 1'b0;
    e.waits = 0;
    case (d)
      0:       if (sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
      1:       if (sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
      default: if (sb2.size() > 0) begin e = sb2.pop_front(); ok = 1'b1; end
    endcase
    return ok;
  endfunction

  // Monitor for one DUT, evaluated on the falling edge.
  task automatic monitor(input int d);
    exp_t e;
    if (!rst[d] || !psel[d]) waits[d] = 0;
    if (pready[d]) begin
      if (!pop(d, e)) begin
        check($sformatf("dut%0d unexpected pready", d), {31'b0, pready[d]}, 32'd0);
      end else begin
        check($sformatf("dut%0d xfer%0d prdata", d, xfers[d]), prdata[d], e.rdata);
        check($sformatf("dut%0d xfer%0d pslverr", d, xfers[d]), {31'b0, pslverr[d]}, {31'b0, e.err});
        check($sformatf("dut%0d xfer%0d wait cycles", d, xfers[d]), 32'(waits[d]), 32'(e.waits));
      end
      xfers[d]++;
      waits[d] = 0;
    end else begin
      if (psel[d] && penable[d]) waits[d]++;
      check($sformatf("dut%0d idle prdata", d), prdata[d], 32'd0);
      check($sformatf("dut%0d idle pslverr", d), {31'b0, pslverr[d]}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) monitor(d);
  end

  // One complete transfer; calling it again straight away is back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err);
    int n;
    push(d, exp_rdata, exp_err);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    n = 0;
    while (!pready[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pready[d]) check($sformatf("dut%0d pready timeout", d), {31'b0, pready[d]}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d, input int cycles);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Setup and enter access for a write that will not be completed normally.
  task automatic start_write(input int d, input logic [7:0] addr, input logic [31:0] wdata);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = 1'b1;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    @(posedge clk); #1;
    penable[d] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; waits[d] = 0; xfers[d] = 0;
    end
    // Reset held for three cycles, then idle.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) rst[d] = 1'b1;
    idle(0, 3);

    // WAIT_CYCLES=1: write/read one register, others read zero.
    xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer(0, 1'b0, 8'h08, 32'h0, 32'hDEADBEEF, 1'b0);
    xfer(0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
    xfer(0, 1'b0, 8'h04, 32'h0, 32'h0, 1'b0);
    xfer(0, 1'b0, 8'h0C, 32'h0, 32'h0, 1'b0);
    xfer(0, 1'b0, 8'h1C, 32'h0, 32'h0, 1'b0);
    xfer(0, 1'b0, 8'h0B, 32'h0, 32'hDEADBEEF, 1'b0);
    idle(0, 2);

    // Out-of-range write and read (index 16 aliases reg 0 if range is ignored).
    xfer(0, 1'b1, 8'h40, 32'h55, 32'h0, ERR_EXP);
    xfer(0, 1'b0, 8'h40, 32'h0, 32'h0, ERR_EXP);
    xfer(0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
    xfer(0, 1'b0, 8'h08, 32'h0, 32'hDEADBEEF, 1'b0);
    xfer(0, 1'b0, 8'hFC, 32'h0, 32'h0, ERR_EXP);
    idle(0, 2);

    // WAIT_CYCLES=0: four back-to-back writes then back-to-back reads.
    for (int i = 0; i < 4; i++) xfer(1, 1'b1, 8'(i * 4), 32'(i + 1), 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) xfer(1, 1'b0, 8'(i * 4), 32'h0, 32'(i + 1), 1'b0);
    idle(1, 2);
    // Access strobe without a setup phase is ignored.
    psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 8'h00; pwdata[1] = 32'hBAD;
    repeat (2) @(posedge clk);
    #1;
    idle(1, 1);
    xfer(1, 1'b0, 8'h00, 32'h0, 32'h1, 1'b0);
    idle(1, 2);

    // WAIT_CYCLES=3: a live register, then abort after one access cycle.
    xfer(2, 1'b1, 8'h08, 32'h12345678, 32'h0, 1'b0);
    xfer(2, 1'b0, 8'h08, 32'h0, 32'h12345678, 1'b0);
    idle(2, 1);
    start_write(2, 8'h04, 32'hA5A5A5A5);
    @(posedge clk); #1;
    idle(2, 2);
    xfer(2, 1'b0, 8'h04, 32'h0, 32'h0, 1'b0);
    xfer(2, 1'b0, 8'h08, 32'h0, 32'h12345678, 1'b0);
    idle(2, 1);

    // Reset pulse in the middle of the wait states.
    start_write(2, 8'h04, 32'hA5A5A5A5);
    @(posedge clk); #3;
    rst[2] = 1'b0;
    #1;
    check("dut2 pready during reset", {31'b0, pready[2]}, 32'd0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    idle(2, 1);
    for (int i = 0; i < 8; i++) xfer(2, 1'b0, 8'(i * 4), 32'h0, 32'h0, 1'b0);
    idle(2, 3);

    check("dut0 scoreboard drained", 32'(sb0.size()), 32'd0);
    check("dut1 scoreboard drained", 32'(sb1.size()), 32'd0);
    check("dut2 scoreboard drained", 32'(sb2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
